// File: rtl/e_mdu_pkg.sv
// Shared constants: ALU selects, MDU op encodings and MDU state encoding.
// MDU_MADD_EN adds the multiply-accumulate ops (encodings always reserved).
package e_mdu_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLT = 4'h5;

  localparam logic [3:0] MDU_MULT  = 4'h0;
  localparam logic [3:0] MDU_MULTU = 4'h1;
  localparam logic [3:0] MDU_DIV   = 4'h2;
  localparam logic [3:0] MDU_DIVU  = 4'h3;
  localparam logic [3:0] MDU_MTHI  = 4'h4;
  localparam logic [3:0] MDU_MTLO  = 4'h5;
  localparam logic [3:0] MDU_MADD  = 4'h6;
  localparam logic [3:0] MDU_MADDU = 4'h7;
  localparam logic [3:0] MDU_MSUB  = 4'h8;
  localparam logic [3:0] MDU_MSUBU = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/e_mdu_div.sv
// Combinational signed/unsigned divider: quotient truncates toward zero,
// remainder takes the dividend's sign. MIN / -1 falls out as q=MIN, r=0.
module e_mdu_div #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] ua, ub, ub_safe, uq, ur;

  always_comb begin
    neg_a    = is_signed & a[WIDTH-1];
    neg_b    = is_signed & b[WIDTH-1];
    ua       = neg_a ? (~a + 1'b1) : a;
    ub       = neg_b ? (~b + 1'b1) : b;
    div_zero = (b == '0);
    // keep the divider free of X on b==0; the result is discarded anyway
    ub_safe  = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : ub;
    uq       = ua / ub_safe;
    ur       = ua % ub_safe;
    q        = (neg_a ^ neg_b) ? (~uq + 1'b1) : uq;
    r        = neg_a ? (~ur + 1'b1) : ur;
  end

endmodule

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu accumulate ops.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t         state;
  logic [7:0]         cnt;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;

  logic               mul_signed, div_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;
  logic [WIDTH-1:0]   div_q, div_r;
  logic               div_zero;

  // Result datapath works off the latched operands, so input changes mid-op are inert
  always_comb begin
    mul_signed = (op_q == MDU_MULT);
`ifdef MDU_MADD_EN
    mul_signed = mul_signed | (op_q == MDU_MADD) | (op_q == MDU_MSUB);
`endif
    div_signed = (op_q == MDU_DIV);
    ext_a      = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q};
    ext_b      = {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};
    prod       = ext_a * ext_b;
    mul_res    = prod;
`ifdef MDU_MADD_EN
    case (op_q)
      MDU_MADD, MDU_MADDU: mul_res = {hi, lo} + prod;
      MDU_MSUB, MDU_MSUBU: mul_res = {hi, lo} - prod;
      default:             mul_res = prod;
    endcase
`endif
  end

  e_mdu_div #(.WIDTH(WIDTH)) u_div (
    .a        (a_q),
    .b        (b_q),
    .is_signed(div_signed),
    .q        (div_q),
    .r        (div_r),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          case (mdu_op)
            MDU_MULT, MDU_MULTU
`ifdef MDU_MADD_EN
            , MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU
`endif
            : begin
              state <= ST_MULT;
              busy  <= 1'b1;
              cnt   <= 8'(MULT_CYCLES - 1);
              op_q  <= mdu_op;
              a_q   <= a;
              b_q   <= b;
            end
            MDU_DIV, MDU_DIVU: begin
              state <= ST_DIV;
              busy  <= 1'b1;
              cnt   <= 8'(DIV_CYCLES - 1);
              op_q  <= mdu_op;
              a_q   <= a;
              b_q   <= b;
            end
            MDU_MTHI: hi <= a;
            MDU_MTLO: lo <= a;
            default: ;
          endcase
        end
        ST_MULT: begin
          if (cnt == '0) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            {hi, lo} <= mul_res;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DIV: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (!div_zero) begin
              hi <= div_r;
              lo <= div_q;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: hand-computed HI/LO results and busy-cycle counts.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mdu_op = 4'hF;
  logic [31:0] a = '0, b = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int vecs = 0;
  int errs = 0;
  int ncyc;

  e_mdu dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdu_op(mdu_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request at negedge; it is taken on the following posedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    start = 1'b1; mdu_op = op; a = va; b = vb;
    @(posedge clk);
    #1;
    start = 1'b0; mdu_op = 4'hF;
  endtask

  // Count cycles busy stays high after acceptance (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input int exp_cyc);
    int n;
    issue(op, va, vb);
    // scramble operands after acceptance; result must use the latched copy
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    wait_done(n);
    check({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
  endtask

  initial begin
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // signed multiply -2 * 3
    run_op("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    run_op("divu", MDU_DIVU, 32'd100, 32'd7, 10);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    run_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    run_op("divovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    // mthi takes effect with no busy cycle, then divide by zero keeps HI/LO
    issue(MDU_MTHI, 32'h0000_1234, 32'd0);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    check("mthi_hi", hi, 32'h0000_1234);
    run_op("div0", MDU_DIV, 32'd5, 32'd0, 10);
    check("div0_hi", hi, 32'h0000_1234);
    check("div0_lo", lo, 32'h8000_0000);

    // multu with a div request during busy; the div must be dropped
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_DIV; a = 32'd9; b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0; mdu_op = 4'hF;
    wait_done(ncyc);
    check("busyign_cycles", 32'(ncyc + 1), 32'd5);
    check("busyign_hi", hi, 32'hFFFF_FFFE);
    check("busyign_lo", lo, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("busyign_idle", {31'b0, busy}, 32'd0);

    // reset in cycle 3 of a mult
    issue(MDU_MULT, 32'd100, 32'd100);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort_lo_held", lo, 32'd0);
    run_op("mult2", MDU_MULT, 32'd6, 32'd7, 5);
    check("mult2_lo", lo, 32'd42);
    check("mult2_hi", hi, 32'd0);

    // accumulate (or no-op when the feature is absent)
    issue(MDU_MTLO, 32'd10, 32'd0);
    check("mtlo_lo", lo, 32'd10);
`ifdef MDU_MADD_EN
    run_op("madd", MDU_MADD, 32'd3, 32'd4, 5);
    check("madd_lo", lo, 32'd22);
    check("madd_hi", hi, 32'd0);
`else
    run_op("madd", MDU_MADD, 32'd3, 32'd4, 0);
    check("madd_lo", lo, 32'd10);
    check("madd_hi", hi, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
